// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: receive FSM state encoding and
// the default bit period (100 MHz clock, 115200 baud).
package uart_pkg;

  localparam int unsigned CLK_PER_BIT_DEFAULT = 868;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Controller-facing signals of the UART receiver.
//   rxd       : serial line into the receiver (idle high, 8N1, LSB first)
//   rd_en     : pop request for the head byte
//   clr_err   : clears the sticky error flags
//   rxdata    : head byte (8'h00 when empty)
//   rx_valid  : FIFO non-empty
//   overrun   : sticky, a byte was dropped on a full FIFO
//   frame_err : sticky, a stop bit was sampled low
// master = controller / line driver side, slave = receiver side.
interface uart_rx_fifo_if;

  logic       rxd;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rxdata;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;

  modport master (
    output rxd, rd_en, clr_err,
    input  rxdata, rx_valid, overrun, frame_err
  );

  modport slave (
    input  rxd, rd_en, clr_err,
    output rxdata, rx_valid, overrun, frame_err
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write request and data; accepted when not full, or when
//                   full and a pop happens on the same edge
//   pop_i         : read request; ignored while empty
//   data_o        : mem[rptr] while non-empty, zero while empty
//   full_o/empty_o/count_o : occupancy status, count in 0..Depth
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FullCnt);
  assign count_o = count_q;

  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a show-ahead receive FIFO.
//   clk  : single clock
//   rstn : asynchronous active-low reset
//   bus  : controller signals (see uart_rx_fifo_if)
// rxd is double-flopped; the FSM samples mid-bit using a counter that runs
// 0..CLK_PER_BIT-1. Good stop bits push the byte, bad ones set frame_err.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
  parameter int unsigned DEPTH       = 16
) (
  input logic           clk,
  input logic           rstn,
  uart_rx_fifo_if.slave bus
);

  localparam int unsigned CntW = $clog2(CLK_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLK_PER_BIT / 2 - 1);

  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            sync1_q, sync2_q;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;
  logic            rxs;
  logic            push_req, frame_set, overrun_set;

  logic                   fifo_full, fifo_empty;
  logic [7:0]             fifo_data;
  logic [$clog2(DEPTH):0] fifo_count;

  assign rxs = sync2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rxs) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (cnt_q == CntHalf) begin
          if (!rxs) begin
            state_d = StData;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          shift_d[idx_q] = rxs;
          cnt_d          = '0;
          if (idx_q == 3'd7) state_d = StStop;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          if (rxs) push_req  = 1'b1;
          else     frame_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Full implies non-empty, so rd_en on the same edge always frees a slot.
  assign overrun_set = push_req && fifo_full && !bus.rd_en;

  // A new error on the clearing edge wins over clr_err.
  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (bus.clr_err) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (overrun_set) overrun_d   = 1'b1;
    if (frame_set)   frame_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      sync1_q     <= bus.rxd;
      sync2_q     <= sync1_q;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  sync_fifo #(
    .Width (8),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .push_i  (push_req),
    .data_i  (shift_q),
    .pop_i   (bus.rd_en),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Occupancy is kept on the FIFO for observability only.
  logic unused_count;
  assign unused_count = ^fifo_count;

  assign bus.rxdata    = fifo_data;
  assign bus.rx_valid  = !fifo_empty;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with CLK_PER_BIT=4, DEPTH=16.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int unsigned ClkPerBit = 4;
  localparam int unsigned Depth     = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(
    .CLK_PER_BIT (ClkPerBit),
    .DEPTH       (Depth)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge just before the
  // stop-sample rising edge, with the line back at idle.
  task automatic send_frame(input logic [7:0] data, input logic stop);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rxd = bits[i];
      repeat (ClkPerBit) @(negedge clk);
    end
    bus.rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check_eq({tag, "_valid"}, 16'(bus.rx_valid), 16'd1);
    check_eq({tag, "_data"}, 16'(bus.rxdata), 16'(exp));
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse_clr;
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rxd     = 1'b1;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    rstn        = 1'b0;
    idle(3);
    check_eq("rst_valid", 16'(bus.rx_valid), 16'd0);
    check_eq("rst_data", 16'(bus.rxdata), 16'h00);
    check_eq("rst_overrun", 16'(bus.overrun), 16'd0);
    check_eq("rst_frame", 16'(bus.frame_err), 16'd0);
    check_eq("rst_state", 16'(dut.state_q), 16'(StIdle));
    rstn = 1'b1;
    idle(4);

    // Single frame, latency and pop.
    send_frame(8'hA5, 1'b1);
    check_eq("a5_before_stop", 16'(bus.rx_valid), 16'd0);
    @(negedge clk);
    check_eq("a5_valid", 16'(bus.rx_valid), 16'd1);
    check_eq("a5_data", 16'(bus.rxdata), 16'hA5);
    check_eq("a5_frame", 16'(bus.frame_err), 16'd0);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check_eq("a5_pop_valid", 16'(bus.rx_valid), 16'd0);
    check_eq("a5_pop_data", 16'(bus.rxdata), 16'h00);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check_eq("empty_pop_count", 16'(dut.u_fifo.count_o), 16'd0);

    // One-cycle glitch on the line.
    bus.rxd = 1'b0;
    @(negedge clk);
    bus.rxd = 1'b1;
    idle(12);
    check_eq("glitch_valid", 16'(bus.rx_valid), 16'd0);
    check_eq("glitch_overrun", 16'(bus.overrun), 16'd0);
    check_eq("glitch_frame", 16'(bus.frame_err), 16'd0);
    check_eq("glitch_state", 16'(dut.state_q), 16'(StIdle));

    // Bad stop bit.
    send_frame(8'h3C, 1'b0);
    @(negedge clk);
    check_eq("3c_frame", 16'(bus.frame_err), 16'd1);
    check_eq("3c_valid", 16'(bus.rx_valid), 16'd0);
    idle(8);
    check_eq("3c_sticky", 16'(bus.frame_err), 16'd1);
    pulse_clr();
    check_eq("3c_clr", 16'(bus.frame_err), 16'd0);

    // Fill, overflow with clr_err on the same edge (set wins), drain with wrap.
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
    send_frame(8'h10, 1'b1);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    check_eq("ovr_set", 16'(bus.overrun), 16'd1);
    check_eq("ovr_count", 16'(dut.u_fifo.count_o), 16'd16);
    check_eq("ovr_frame", 16'(bus.frame_err), 16'd0);
    for (int i = 0; i < 16; i++) pop_expect($sformatf("ovr_pop%0d", i), 8'(i));
    check_eq("ovr_drain_valid", 16'(bus.rx_valid), 16'd0);
    check_eq("ovr_drain_data", 16'(bus.rxdata), 16'h00);
    check_eq("ovr_sticky", 16'(bus.overrun), 16'd1);
    pulse_clr();
    check_eq("ovr_clr", 16'(bus.overrun), 16'd0);

    // Full FIFO, pop on the stop-sample edge of 0x77.
    for (int i = 0; i < 16; i++) send_frame(8'h60 + 8'(i), 1'b1);
    send_frame(8'h77, 1'b1);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check_eq("simul_overrun", 16'(bus.overrun), 16'd0);
    check_eq("simul_count", 16'(dut.u_fifo.count_o), 16'd16);
    for (int i = 1; i < 16; i++) pop_expect($sformatf("simul_pop%0d", i), 8'h60 + 8'(i));
    pop_expect("simul_last", 8'h77);
    check_eq("simul_empty", 16'(bus.rx_valid), 16'd0);

    // Reset mid-frame with a byte already queued.
    send_frame(8'h42, 1'b1);
    @(negedge clk);
    check_eq("pre_rst_valid", 16'(bus.rx_valid), 16'd1);
    bus.rxd = 1'b0;
    idle(ClkPerBit);
    for (int i = 0; i < 3; i++) begin
      bus.rxd = i[0] ? 1'b0 : 1'b1;   // 0x55: bit0=1, bit1=0, bit2=1
      idle(ClkPerBit);
    end
    bus.rxd = 1'b0;                   // bit3 of 0x55
    idle(2);
    check_eq("mid_state", 16'(dut.state_q), 16'(StData));
    check_eq("mid_idx", 16'(dut.idx_q), 16'd3);
    rstn    = 1'b0;
    bus.rxd = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", 16'(bus.rx_valid), 16'd0);
    check_eq("mid_rst_data", 16'(bus.rxdata), 16'h00);
    check_eq("mid_rst_state", 16'(dut.state_q), 16'(StIdle));
    idle(2);
    rstn = 1'b1;
    idle(4);
    send_frame(8'h81, 1'b1);
    @(negedge clk);
    check_eq("81_overrun", 16'(bus.overrun), 16'd0);
    check_eq("81_frame", 16'(bus.frame_err), 16'd0);
    pop_expect("81", 8'h81);
    check_eq("81_empty", 16'(bus.rx_valid), 16'd0);
    idle(10);
    check_eq("81_quiet", 16'(bus.rx_valid), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
